// File: rtl/clut_banked.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clut_banked                                                              |
// | Multi-bank colour lookup table with frame-synchronised bank switching    |
// | and a bank-to-bank copy engine. Optional macro: CLUT_TRANSP_EN (transp). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module clut_banked #(
   parameter int    COLRW      = 12,
   parameter int    CIDXW      = 4,
   parameter int    NBANK      = 4,
   parameter string F_PAL      = "",
   parameter int    TRANSP_IDX = 0,
   localparam int   BANKW      = $clog2(NBANK)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_start,
   input  logic [BANKW-1:0] bank_sel,
   output logic [BANKW-1:0] bank_active,
   input  logic             rd_en,
   input  logic [CIDXW-1:0] cidx_read,
   output logic [COLRW-1:0] colr_out,
   output logic             colr_valid,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [BANKW-1:0] wr_bank,
   input  logic [CIDXW-1:0] cidx_write,
   input  logic [COLRW-1:0] colr_in,
   input  logic             copy_start,
   input  logic [BANKW-1:0] copy_src,
   input  logic [BANKW-1:0] copy_dst,
   output logic             copy_busy,
   output logic             copy_done
`ifdef CLUT_TRANSP_EN
   ,
   output logic             transp
`endif
);

   localparam int             c_addrw = BANKW + CIDXW;
   localparam int             c_words = NBANK << CIDXW;
   localparam logic [CIDXW:0] c_last  = (CIDXW+1)'((1 << CIDXW) - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   generate
      if (NBANK < 2 || (NBANK & (NBANK - 1)) != 0 ||
          TRANSP_IDX < 0 || TRANSP_IDX >= (1 << CIDXW)) begin : g_param_err
         $error("clut_banked: invalid parameter set");
      end
   endgenerate

   // Two identical copies so the display port and the copy engine each own a read port.
   logic [COLRW-1:0] r_mem_disp [c_words];
   logic [COLRW-1:0] r_mem_copy [c_words];

   state_t             r_state;
   state_t             w_state_next;
   logic               r_ready_en;
   logic [BANKW-1:0]   r_src;
   logic [BANKW-1:0]   r_dst;
   logic [CIDXW:0]     r_idx;
   logic [CIDXW:0]     w_idx_inc;
   logic [COLRW-1:0]   r_rd_data;
   logic [COLRW-1:0]   r_cp_data;
   logic               r_rd_v;
   logic               w_copy_go;
   logic               w_cp_re;
   logic [c_addrw-1:0] w_cp_raddr;
   logic               w_we;
   logic [c_addrw-1:0] w_waddr;
   logic [COLRW-1:0]   w_wdata;

   assign w_idx_inc = r_idx + 1'b1;
   assign w_copy_go = (r_state == ST_IDLE) && copy_start;
   assign wr_ready  = (r_state == ST_IDLE) && r_ready_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      copy_busy    = 1'b0;
      copy_done    = 1'b0;
      w_cp_re      = 1'b0;
      w_cp_raddr   = {r_src, r_idx[CIDXW-1:0]};
      w_we         = 1'b0;
      w_waddr      = {wr_bank, cidx_write};
      w_wdata      = colr_in;
      case (r_state)
         ST_IDLE: begin
            w_we = wr_valid && r_ready_en;
            if (copy_start) begin
               w_state_next = ST_PRIME;
            end
         end
         ST_PRIME: begin
            copy_busy    = 1'b1;
            w_cp_re      = 1'b1;
            w_state_next = ST_RUN;
         end
         ST_RUN: begin
            // Write entry i from the read register while fetching entry i+1.
            copy_busy  = 1'b1;
            w_cp_re    = 1'b1;
            w_cp_raddr = {r_src, w_idx_inc[CIDXW-1:0]};
            w_we       = 1'b1;
            w_waddr    = {r_dst, r_idx[CIDXW-1:0]};
            w_wdata    = r_cp_data;
            if (r_idx == c_last) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            copy_busy    = 1'b1;
            copy_done    = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Storage is never reset; non-blocking reads give read-first behaviour.
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem_disp[w_waddr] <= w_wdata;
         r_mem_copy[w_waddr] <= w_wdata;
      end
      if (rd_en) begin
         r_rd_data <= r_mem_disp[{bank_active, cidx_read}];
      end
      if (w_cp_re) begin
         r_cp_data <= r_mem_copy[w_cp_raddr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ready_en  <= 1'b0;
         bank_active <= '0;
         r_rd_v      <= 1'b0;
         colr_valid  <= 1'b0;
         colr_out    <= '0;
         r_src       <= '0;
         r_dst       <= '0;
         r_idx       <= '0;
      end else begin
         r_ready_en <= 1'b1;
         if (frame_start) begin
            bank_active <= bank_sel;
         end
         r_rd_v     <= rd_en;
         colr_valid <= r_rd_v;
         if (r_rd_v) begin
            colr_out <= r_rd_data;
         end
         if (w_copy_go) begin
            r_src <= copy_src;
            r_dst <= copy_dst;
            r_idx <= '0;
         end else if (r_state == ST_RUN) begin
            r_idx <= w_idx_inc;
         end
      end
   end

`ifdef CLUT_TRANSP_EN
   localparam logic [CIDXW-1:0] c_transp_idx = CIDXW'(TRANSP_IDX);

   logic r_tr_d1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tr_d1 <= 1'b0;
         transp  <= 1'b0;
      end else begin
         r_tr_d1 <= rd_en && (cidx_read == c_transp_idx);
         transp  <= r_rd_v && r_tr_d1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_clut_banked.sv
`default_nettype none
// Testbench for clut_banked: table vectors, hand-written copy/reset sequences
// and randomized traffic checked against a flat palette array model.
module tb_clut_banked;
   localparam int COLRW = 12;
   localparam int CIDXW = 4;
   localparam int NBANK = 4;
   localparam int BANKW = 2;
   localparam int DEPTH = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             frame_start = 1'b0;
   logic [BANKW-1:0] bank_sel = '0;
   logic [BANKW-1:0] bank_active;
   logic             rd_en = 1'b0;
   logic [CIDXW-1:0] cidx_read = '0;
   logic [COLRW-1:0] colr_out;
   logic             colr_valid;
   logic             wr_valid = 1'b0;
   logic             wr_ready;
   logic [BANKW-1:0] wr_bank = '0;
   logic [CIDXW-1:0] cidx_write = '0;
   logic [COLRW-1:0] colr_in = '0;
   logic             copy_start = 1'b0;
   logic [BANKW-1:0] copy_src = '0;
   logic [BANKW-1:0] copy_dst = '0;
   logic             copy_busy;
   logic             copy_done;
`ifdef CLUT_TRANSP_EN
   logic             transp;
`endif

   clut_banked dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .bank_sel    (bank_sel),
      .bank_active (bank_active),
      .rd_en       (rd_en),
      .cidx_read   (cidx_read),
      .colr_out    (colr_out),
      .colr_valid  (colr_valid),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_bank     (wr_bank),
      .cidx_write  (cidx_write),
      .colr_in     (colr_in),
      .copy_start  (copy_start),
      .copy_src    (copy_src),
      .copy_dst    (copy_dst),
      .copy_busy   (copy_busy),
      .copy_done   (copy_done)
`ifdef CLUT_TRANSP_EN
      ,
      .transp      (transp)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [COLRW-1:0] model [NBANK*DEPTH];
   int m_bank = 0;

   typedef struct {
      int               bank;
      int               idx;
      logic [COLRW-1:0] wdata;
      logic [COLRW-1:0] exp;
   } vec_t;
   vec_t vecs [6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic wr(int b, int i, logic [COLRW-1:0] d);
      int   n = 0;
      logic acc;
      wr_valid   = 1'b1;
      wr_bank    = BANKW'(b);
      cidx_write = CIDXW'(i);
      colr_in    = d;
      do begin
         acc = wr_ready;
         tick();
         n++;
      end while (!acc && n < 50);
      wr_valid = 1'b0;
      if (!acc) chk("wr_timeout", 0, 1);
      model[b*DEPTH + i] = d;
   endtask

   task automatic switch_bank(int b);
      bank_sel    = BANKW'(b);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      m_bank      = b;
      chk("bank_active", 32'(bank_active), b);
   endtask

   task automatic rd_check(int idx, logic [COLRW-1:0] exp, string nm);
      rd_en     = 1'b1;
      cidx_read = CIDXW'(idx);
      tick();
      rd_en = 1'b0;
      chk({nm, "_valid_early"}, 32'(colr_valid), 0);
      tick();
      chk({nm, "_valid"}, 32'(colr_valid), 1);
      chk(nm, 32'(colr_out), 32'(exp));
   endtask

   task automatic read_bank(int b, int idx, string nm);
      if (m_bank != b) switch_bank(b);
      rd_check(idx, model[b*DEPTH + idx], nm);
   endtask

   task automatic copy_model(int s, int d);
      for (int i = 0; i < DEPTH; i++) model[d*DEPTH + i] = model[s*DEPTH + i];
   endtask

   task automatic copy_basic(int s, int d);
      int n = 0;
      int dn = 0;
      copy_src   = BANKW'(s);
      copy_dst   = BANKW'(d);
      copy_start = 1'b1;
      tick();
      copy_start = 1'b0;
      while (copy_busy && n < 40) begin
         if (copy_done) dn++;
         tick();
         n++;
      end
      chk("copy_cycles", n, DEPTH + 2);
      chk("copy_done_pulses", dn, 1);
      copy_model(s, d);
   endtask

   // Each read is time-stamped; its result must appear exactly two edges later.
   task automatic burst(int n);
      logic             iv [64];
      logic [COLRW-1:0] id [64];
      logic [CIDXW-1:0] ix [64];
      for (int t = 0; t <= n; t++) begin
         if (t < n) begin
            iv[t] = ($urandom_range(0, 3) != 0);
            ix[t] = CIDXW'($urandom);
         end else begin
            iv[t] = 1'b0;
            ix[t] = '0;
         end
         id[t]     = model[m_bank*DEPTH + int'(ix[t])];
         rd_en     = iv[t];
         cidx_read = ix[t];
         tick();
         if (t >= 1) begin
            chk("burst_valid", 32'(colr_valid), 32'(iv[t-1]));
            if (iv[t-1]) chk("burst_data", 32'(colr_out), 32'(id[t-1]));
`ifdef CLUT_TRANSP_EN
            chk("burst_transp", 32'(transp), 32'(iv[t-1] && ix[t-1] == 0));
`endif
         end
      end
      rd_en = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, dn, rdy_bad, done_at, op, b;

      vecs[0] = '{2, 5,  12'h123, 12'h123};
      vecs[1] = '{1, 3,  12'hF80, 12'hF80};
      vecs[2] = '{0, 0,  12'hFFF, 12'hFFF};
      vecs[3] = '{3, 15, 12'h000, 12'h000};
      vecs[4] = '{0, 15, 12'hA5A, 12'hA5A};
      vecs[5] = '{3, 0,  12'h5A5, 12'h5A5};

      // Reset values
      #2 rst_n = 1'b0;
      #1;
      chk("rst_colr_out", 32'(colr_out), 0);
      chk("rst_colr_valid", 32'(colr_valid), 0);
      chk("rst_bank_active", 32'(bank_active), 0);
      chk("rst_copy_busy", 32'(copy_busy), 0);
      chk("rst_copy_done", 32'(copy_done), 0);
      repeat (2) tick();
      chk("rst_wr_ready", 32'(wr_ready), 0);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("wr_ready_pre_edge", 32'(wr_ready), 0);
      tick();
      chk("wr_ready_post_reset", 32'(wr_ready), 1);

      for (int bb = 0; bb < NBANK; bb++)
         for (int i = 0; i < DEPTH; i++)
            wr(bb, i, COLRW'($urandom));

      // Table vectors: write then read back on the following cycle
      for (int k = 0; k < 6; k++) begin
         if (m_bank != vecs[k].bank) switch_bank(vecs[k].bank);
         wr(vecs[k].bank, vecs[k].idx, vecs[k].wdata);
         rd_check(vecs[k].idx, vecs[k].exp, "table");
      end

      // Read in the frame_start cycle uses the old bank
      if (m_bank != 0) switch_bank(0);
      bank_sel    = 2'd1;
      frame_start = 1'b1;
      rd_en       = 1'b1;
      cidx_read   = 4'd3;
      tick();
      frame_start = 1'b0;
      rd_en       = 1'b0;
      m_bank      = 1;
      chk("fs_bank_active", 32'(bank_active), 1);
      tick();
      chk("fs_old_bank_data", 32'(colr_out), 32'(model[3]));
      rd_check(3, 12'hF80, "bank1_idx3");

      // Copy 2->0 with a re-pulsed start and a write held across the copy
      copy_src   = 2'd2;
      copy_dst   = 2'd0;
      copy_start = 1'b1;
      tick();
      copy_start = 1'b0;
      n = 0; dn = 0; rdy_bad = 0; done_at = -1;
      while (copy_busy && n < 40) begin
         if (wr_ready) rdy_bad++;
         if (copy_done) begin dn++; done_at = n; end
         if (n == 2) begin
            wr_valid = 1'b1; wr_bank = 2'd3; cidx_write = 4'd7; colr_in = 12'hABC;
         end
         if (n == 4) begin copy_start = 1'b1; copy_src = 2'd1; copy_dst = 2'd3; end
         if (n == 5) copy_start = 1'b0;
         tick();
         n++;
      end
      chk("copy_busy_cycles", n, 18);
      chk("copy_done_count", dn, 1);
      chk("copy_done_cycle", done_at, 17);
      chk("wr_ready_during_copy", rdy_bad, 0);
      chk("wr_ready_after_done", 32'(wr_ready), 1);
      tick();
      wr_valid = 1'b0;
      chk("second_start_ignored", 32'(copy_busy), 0);
      copy_model(2, 0);
      model[3*DEPTH + 7] = 12'hABC;
      if (m_bank != 0) switch_bank(0);
      rd_check(5, 12'h123, "copy_b0_idx5");
      for (int i = 0; i < DEPTH; i++) read_bank(0, i, "copy_bank0");
      read_bank(3, 7, "held_write");
      read_bank(3, 0, "bank3_untouched");

      // Same-cycle write and read of one address returns the old value
      switch_bank(2);
      wr_valid = 1'b1; wr_bank = 2'd2; cidx_write = 4'd5; colr_in = 12'h456;
      rd_en = 1'b1; cidx_read = 4'd5;
      tick();
      wr_valid = 1'b0;
      rd_en    = 1'b0;
      tick();
      chk("read_first_old", 32'(colr_out), 32'h123);
      model[2*DEPTH + 5] = 12'h456;
      rd_check(5, 12'h456, "read_after_write");

      // Reset five cycles into a copy
      copy_src = 2'd1; copy_dst = 2'd3; copy_start = 1'b1;
      rd_en = 1'b1; cidx_read = 4'd4;
      tick();
      copy_start = 1'b0;
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      chk("abort_copy_busy", 32'(copy_busy), 0);
      chk("abort_copy_done", 32'(copy_done), 0);
      chk("abort_colr_valid", 32'(colr_valid), 0);
      chk("abort_colr_out", 32'(colr_out), 0);
      chk("abort_bank_active", 32'(bank_active), 0);
      chk("abort_wr_ready", 32'(wr_ready), 0);
      rd_en = 1'b0;
      repeat (2) tick();
      @(negedge clk) rst_n = 1'b1;
      tick();
      m_bank = 0;
      chk("abort_wr_ready_back", 32'(wr_ready), 1);
      copy_basic(1, 3);
      for (int i = 0; i < DEPTH; i++) read_bank(3, i, "recopy_bank3");

`ifdef CLUT_TRANSP_EN
      rd_en = 1'b1; cidx_read = 4'd0;
      tick();
      cidx_read = 4'd1;
      tick();
      rd_en = 1'b0;
      chk("transp_idx0", 32'(transp), 1);
      chk("transp_idx0_valid", 32'(colr_valid), 1);
      tick();
      chk("transp_idx1", 32'(transp), 0);
      chk("transp_idx1_valid", 32'(colr_valid), 1);
      tick();
`endif

      // Randomized traffic
      for (int k = 0; k < 150; k++) begin
         op = $urandom_range(0, 9);
         if (op < 4) begin
            wr($urandom_range(0, NBANK-1), $urandom_range(0, DEPTH-1), COLRW'($urandom));
         end else if (op < 5) begin
            copy_basic($urandom_range(0, NBANK-1), $urandom_range(0, NBANK-1));
         end else if (op < 7) begin
            read_bank($urandom_range(0, NBANK-1), $urandom_range(0, DEPTH-1), "rand_read");
         end else begin
            b = $urandom_range(0, NBANK-1);
            if (m_bank != b) switch_bank(b);
            burst($urandom_range(4, 20));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
